// File: rtl/reg_file_sequencer.sv
// Multicycle sequencer driving a 4x8 register bank: IDLE -> DECODE -> EXEC -> WB.
// Latency: 4 cycles per writing instruction, 3 for NOP/illegal; instr_ready only in IDLE.
module reg_file_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] sr1,
    output logic [ADDR_W-1:0] sr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [ADDR_W-1:0] dr,
    output logic              write,
    output logic [DATA_W-1:0] wr_data,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;

    state_t            state;
    state_t            state_nx;
    logic [15:0]       ir;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_flags;
    logic              legal;
    logic              capture;

    assign opcode = ir[15:12];
    assign imm    = DATA_W'(ir[7:0]);
    assign sum    = {1'b0, rd_data1} + {1'b0, rd_data2};

    always_comb begin
        alu_res   = '0;
        alu_c     = flag_c;
        alu_flags = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                alu_res   = sum[DATA_W-1:0];
                alu_c     = sum[DATA_W];
                alu_flags = 1'b1;
            end
            OP_SUB: begin
                alu_res   = rd_data1 - rd_data2;
                alu_c     = (rd_data1 < rd_data2);
                alu_flags = 1'b1;
            end
            OP_AND: begin
                alu_res   = rd_data1 & rd_data2;
                alu_c     = 1'b0;
                alu_flags = 1'b1;
            end
            OP_OR: begin
                alu_res   = rd_data1 | rd_data2;
                alu_c     = 1'b0;
                alu_flags = 1'b1;
            end
            OP_XOR: begin
                alu_res   = rd_data1 ^ rd_data2;
                alu_c     = 1'b0;
                alu_flags = 1'b1;
            end
            OP_MOV: alu_res = rd_data1;
            OP_LDI: alu_res = imm;
            default: legal = 1'b0;
        endcase
    end

    // Strobes are decoded from state so an asynchronous reset drops them immediately.
    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        write       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    capture  = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                if (!legal) begin
                    err      = 1'b1;
                    state_nx = S_IDLE;
                end else if (opcode == OP_NOP) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_WB: begin
                write    = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ir      <= '0;
            sr1     <= '0;
            sr2     <= '0;
            dr      <= '0;
            wr_data <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            state <= state_nx;
            if (capture) begin
                ir  <= instr;
                dr  <= ADDR_W'(instr[11:10]);
                sr1 <= ADDR_W'(instr[9:8]);
                sr2 <= ADDR_W'(instr[7:6]);
            end
            if (state == S_EXEC && legal && opcode != OP_NOP) begin
                wr_data <= alu_res;
                if (alu_flags) begin
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                end
            end
        end
    end

endmodule
